// File: rtl/delay_arbiter_if.sv
// Request/delay/done bundle between the two timing clients and the shared delay timer.
// Handshake: a client holds req high (dly stable at grant) until it sees done high for one cycle,
// then drops req on that edge; dropping req early aborts the running delay.
interface delay_arbiter_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       req;
    logic [CNT_W-1:0] dly0;
    logic [CNT_W-1:0] dly1;
    logic [1:0]       done;
    logic             busy;
    logic             grant_id;

    modport master (
        output req, dly0, dly1,
        input  done, busy, grant_id
    );

    modport slave (
        input  req, dly0, dly1,
        output done, busy, grant_id
    );
endinterface

// File: rtl/delay_arbiter.sv
// Shared down-counting delay timer granted round-robin to two clients; the winner
// gets a one-cycle done pulse after its sampled delay expires.
module delay_arbiter #(
    parameter int CNT_W = 32
) (
    input  logic                 in_clk,
    input  logic                 rst,
    delay_arbiter_if.slave       bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [CNT_W-1:0] sel_dly;
    logic             grant, grant_nx;
    logic             rr_last, rr_nx;
    logic             winner;
    logic [1:0]       done_q;
    logic             busy_q;

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            grant   <= 1'b0;
            rr_last <= 1'b1;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            grant   <= grant_nx;
            rr_last <= rr_nx;
            // Outputs are registered decodes of the next state, so they line up with state.
            done_q  <= (state_nx == DONE) ? (grant_nx ? 2'b10 : 2'b01) : 2'b00;
            busy_q  <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        grant_nx = grant;
        rr_nx    = rr_last;
        winner   = (bus.req == 2'b11) ? ~rr_last : bus.req[1];
        sel_dly  = winner ? bus.dly1 : bus.dly0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    grant_nx = winner;
                    count_nx = (sel_dly == '0) ? CNT_W'(1) : sel_dly;
                    state_nx = COUNT;
                end
            end
            COUNT: begin
                // Only the owner's request matters; the other client waits its turn.
                if (!bus.req[grant]) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end else if (count == CNT_W'(1)) begin
                    state_nx = DONE;
                end else begin
                    count_nx = count - CNT_W'(1);
                end
            end
            DONE: begin
                rr_nx    = grant;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
    end

    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant;
    assign state_dbg    = state;

endmodule
